seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexing scan controller that shares one BCD-to-7-segment decoder (counter_to_7seg) between NUM_DIGITS display digits. It holds a tear-free snapshot of the digit values and steps through the digits at a prescaled rate. For each digit it drives that digit's code to the decoder and asserts a one-hot digit enable. It inserts a blanking guard before each digit to prevent ghosting and can suppress leading zeros.

## Interface
- NUM_DIGITS, 4: digits scanned, 2..8.
- PRESCALE, 1000: clock cycles per digit slot, including blanking.
- BLANK_CYCLES, 2: blanked cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < PRESCALE.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable_i  in  1  scan enable; low forces IDLE.
- digits_i  in  4*NUM_DIGITS  digit codes; digit k = bits [4k+3:4k]; digit 0 = least significant.
- load_i  in  1  one-cycle strobe; captures digits_i.
- lz_suppress_i  in  1  blank leading zeros when high.
- bcd_o  out  4  code to the decoder's count_i; 4'hF = blank.
- dig_sel_o  out  NUM_DIGITS  one-hot digit enable, active-high.
- frame_done_o  out  1  one-cycle pulse on the last cycle of the last digit slot.

## Operation
- State machine: IDLE, BLANK, SHOW.
  - IDLE → BLANK (digit 0, slot counter 0) when enable_i=1.
  - BLANK → SHOW after BLANK_CYCLES cycles.
  - SHOW → BLANK of the next digit after PRESCALE-BLANK_CYCLES cycles. Digit index wraps NUM_DIGITS-1 → 0.
  - Any state → IDLE when enable_i=0. This takes effect the next cycle and clears the slot counter and digit index.
- Snapshot registers:
  - staging: load_i=1 copies digits_i into staging and sets pending.
  - shadow: displayed values.
  - At a frame boundary (the cycle frame_done_o=1):
    - if load_i=1 in that same cycle, shadow ← digits_i and pending clears;
    - else if pending, shadow ← staging and pending clears.
  - In IDLE, the first load_i goes directly to shadow.
  - Shadow never changes mid-frame.
- bcd_o:
  - In BLANK and SHOW: the shadow code of the current digit, or 4'hF when suppressed.
  - In IDLE: 4'hF.
  - Codes >9 pass through unchanged; the decoder blanks them.
- Leading-zero suppression: when lz_suppress_i=1, digit k is suppressed if digits k..NUM_DIGITS-1 of shadow are all 0. Digit 0 is never suppressed.
- dig_sel_o:
  - SHOW: bit[index]=1.
  - BLANK and IDLE: all zero.
  - A suppressed digit still gets its slot, with bcd_o=4'hF.

## Timing
- Reset values (rst_n=0 at a clk edge):
  - state IDLE;
  - bcd_o=4'hF;
  - dig_sel_o=0;
  - frame_done_o=0;
  - shadow=0, staging=0, pending=0.
- All outputs are registered; no combinational input-to-output path.
- Digit-to-digit latency: exactly PRESCALE cycles. Frame period: NUM_DIGITS*PRESCALE cycles.
- enable_i rise in cycle t: first BLANK cycle visible at t+1. dig_sel_o first asserts at t+1+BLANK_CYCLES.
- load_i in cycle t: the new value appears on bcd_o no earlier than the first slot after the next frame_done_o.
- lz_suppress_i is sampled each cycle; a change is visible the next cycle.
- Reset mid-frame returns to IDLE and discards staging and pending.
- enable_i drop mid-frame preserves shadow and staging.

## Structure
- Shared package seg_pkg holds:
  - state enum localparams (IDLE/BLANK/SHOW);
  - BLANK_CODE = 4'hF;
  - digit width = 4.
- One sub-module, scan_prescaler: slot counter that emits blank_end and slot_end strikes. The FSM, snapshot and suppression logic stay in the top.
- The decoder is instantiated by the parent; it is not inside this block.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
- **Reset:** rst_n=0 during an active scan → next cycle bcd_o=F, dig_sel_o=0, frame_done_o=0. Re-enable → digit 0 after 1+2 cycles.
- **Scan sequence:** load 0x1234, enable → repeating sequence:
  - dig_sel 0001 with bcd 4 for 6 cycles, then 0010 with bcd 3, 0100 with bcd 2, 1000 with bcd 1;
  - each slot preceded by 2 cycles of dig_sel=0;
  - frame_done pulses every 32 cycles.
- **Tear-free load:** load 0x5678 mid-frame → the current frame continues showing 1234; 5678 appears from the next digit-0 slot. Also: load coinciding with frame_done → the new value is used next frame.
- **Leading-zero suppression:** shadow 0x0050 with lz=1 → bcd sequence 0,5,F,F. With lz=0 → 0,5,0,0. Shadow 0x0000 with lz=1 → 0,F,F,F.
- **Enable drop:** enable_i=0 mid-SHOW → IDLE next cycle, outputs blank. Re-enable → restarts at digit 0, shadow intact.
- **Pass-through:** digit code 4'hA → bcd_o=A during its slot, dig_sel still asserted.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared state encoding and digit constants for the segment scan controller
package seg_pkg;
  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] BLANK_CODE = 4'hF;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-slot cycle counter flagging the end of blanking and the end of the slot
module scan_prescaler #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic blank_end_o,
  output logic slot_end_o
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    slot_end_o  = cnt_q == CW'(PRESCALE - 1);
    blank_end_o = cnt_q == CW'(BLANK_CYCLES - 1);
    cnt_d       = (!run_i || slot_end_o) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed digit scanner with tear-free snapshot, blanking guard and leading-zero suppression
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic [DIG_W*NUM_DIGITS-1:0] digits_i,
  input  logic                        load_i,
  input  logic                        lz_suppress_i,
  output logic [DIG_W-1:0]            bcd_o,
  output logic [NUM_DIGITS-1:0]       dig_sel_o,
  output logic                        frame_done_o
);
  localparam int IW = $clog2(NUM_DIGITS);
  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [DIG_W*NUM_DIGITS-1:0] shadow_q, shadow_d, staging_q, staging_d;
  logic                        pending_q, pending_d, lz_q;
  logic                        blank_end, slot_end, last, zero_run;
  logic [NUM_DIGITS-1:0]       sup;
  scan_prescaler #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES)) u_pre (
    .clk(clk), .rst_n(rst_n), .run_i(enable_i && state_q != IDLE),
    .blank_end_o(blank_end), .slot_end_o(slot_end)
  );
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last         = idx_q == IW'(NUM_DIGITS - 1);
    frame_done_o = state_q == SHOW && slot_end && last;
    if (!enable_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (state_q == IDLE) state_d = BLANK;
    else if (state_q == BLANK && blank_end) state_d = SHOW;
    else if (state_q == SHOW && slot_end) begin
      state_d = BLANK;
      idx_d   = last ? '0 : idx_q + 1'b1;
    end
    staging_d = load_i ? digits_i : staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // shadow only moves at a frame boundary, or immediately when nothing is being displayed
    if (state_q == IDLE && load_i) begin
      shadow_d  = digits_i;
      pending_d = 1'b0;
    end else if (frame_done_o) begin
      shadow_d  = load_i ? digits_i : pending_q ? staging_q : shadow_q;
      pending_d = 1'b0;
    end else if (load_i) pending_d = 1'b1;
    sup      = '0;
    zero_run = lz_q;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && shadow_q[k*DIG_W +: DIG_W] == '0;
      sup[k]   = zero_run && k != 0;
    end
    bcd_o     = (state_q == IDLE || sup[idx_q]) ? BLANK_CODE : shadow_q[idx_q*DIG_W +: DIG_W];
    dig_sel_o = state_q == SHOW ? NUM_DIGITS'(1) << idx_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      staging_q <= '0;
      pending_q <= 1'b0;
      lz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
      lz_q      <= lz_suppress_i;
    end
  end
endmodule
